seg_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment bus driven by seg_mux. Samples active-low an/seg/dp,

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg7_to_hex.sv | 19 +
 rtl/seg_capture.sv | 89 ++++++++
 tb/tb_seg_capture.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment constants for the seg_capture receive path
package seg_pkg;
  localparam int NDIG = 4;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66, SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F, SEG_9 = 7'h6F, SEG_A_HEX = 7'h77, SEG_B_HEX = 7'h7C;
  localparam logic [6:0] SEG_C_HEX = 7'h39, SEG_D_HEX = 7'h5E, SEG_E_HEX = 7'h79, SEG_F_HEX = 7'h71;
  localparam logic [6:0] SEG_TAB [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A_HEX, SEG_B_HEX, SEG_C_HEX, SEG_D_HEX, SEG_E_HEX, SEG_F_HEX};
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: active-high gfedcba pattern to hex nibble, ok=0 when no table entry matches
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       ok,
  output logic [3:0] hex
);
  always_comb begin
    ok = 1'b0;
    hex = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TAB[i]) begin
        ok = 1'b1;
        hex = 4'(i);
      end
    end
  end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed active-low 7-segment bus and rebuilds coherent 4-digit frames
module seg_capture
  import seg_pkg::*;
#(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  input  logic [3:0] dp,
  output logic [7:0] digit_a,
  output logic [7:0] digit_b,
  output logic [7:0] digit_c,
  output logic [7:0] digit_d,
  output logic [3:0] dp_out,
  output logic [3:0] hex_a,
  output logic [3:0] hex_b,
  output logic [3:0] hex_c,
  output logic [3:0] hex_d,
  output logic [3:0] hex_ok,
  output logic       frame_valid,
  output logic       stale
);
  logic [15:0] s1, s2, prv;
  logic [3:0] an_s, dp_s, sel, seen, seen_nx, sh_dp, dec_ok;
  logic [7:0] seg_s;
  logic [7:0] sh_seg [NDIG];
  logic [3:0] dec_hex [NDIG];
  logic [CNT_W-1:0] cnt, tcnt;
  logic armed, frame_go, valid, same, cap, to;
  assign an_s = s2[15:12];
  assign seg_s = s2[11:4];
  assign dp_s = s2[3:0];
  assign sel = ~an_s;
  assign valid = $onehot(sel);
  assign same = s2 == prv;
  assign cap = armed && valid && same && cnt == CNT_W'(SETTLE - 2);
  assign to = !cap && tcnt == CNT_W'(TIMEOUT - 1);
  assign seen_nx = (frame_go || to ? 4'h0 : seen) | (cap ? sel : 4'h0);
  for (genvar i = 0; i < NDIG; i++) begin : g_dec
    seg7_to_hex u_dec (.pat(sh_seg[i][SEG_G:SEG_A]), .ok(dec_ok[i]), .hex(dec_hex[i]));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      prv <= '0;
      cnt <= '0;
      tcnt <= '0;
      armed <= 1'b0;
      seen <= '0;
      frame_go <= 1'b0;
      for (int i = 0; i < NDIG; i++) sh_seg[i] <= '0;
      sh_dp <= '0;
      {digit_a, digit_b, digit_c, digit_d} <= '0;
      {hex_a, hex_b, hex_c, hex_d} <= '0;
      dp_out <= '0;
      hex_ok <= '0;
      frame_valid <= 1'b0;
      stale <= 1'b1;
    end else begin
      s1 <= {an, seg, dp};
      s2 <= s1;
      prv <= s2;
      cnt <= (!valid || !same) ? '0 : (cnt == CNT_W'(SETTLE - 1)) ? cnt : cnt + 1'b1;
      armed <= (!valid || cap) ? 1'b0 : (an_s != prv[15:12]) ? 1'b1 : armed;
      tcnt <= cap ? '0 : (tcnt == CNT_W'(TIMEOUT - 1)) ? tcnt : tcnt + 1'b1;
      seen <= seen_nx;
      frame_go <= cap && &seen_nx;
      for (int i = 0; i < NDIG; i++) begin
        if (cap && sel[i]) begin
          sh_seg[i] <= ~seg_s;
          sh_dp[i] <= ~dp_s[i];
        end
      end
      frame_valid <= frame_go;
      if (frame_go) begin
        {digit_d, digit_c, digit_b, digit_a} <= {sh_seg[3], sh_seg[2], sh_seg[1], sh_seg[0]};
        {hex_d, hex_c, hex_b, hex_a} <= {dec_hex[3], dec_hex[2], dec_hex[1], dec_hex[0]};
        dp_out <= sh_dp;
        hex_ok <= dec_ok;
      end
      stale <= frame_go ? 1'b0 : to ? 1'b1 : stale;
    end
  end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed scans with a frame scoreboard checked on every frame_valid pulse
module tb_seg_capture;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] an = 4'hF, dp = 4'hF;
  logic [7:0] seg = 8'hFF;
  logic [7:0] digit_a, digit_b, digit_c, digit_d;
  logic [3:0] dp_out, hex_a, hex_b, hex_c, hex_d, hex_ok;
  logic frame_valid, stale;

  typedef struct packed {
    logic [31:0] dig;
    logic [3:0]  dpo;
    logic [15:0] hex;
    logic [3:0]  ok;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  seg_capture #(.SETTLE(4), .TIMEOUT(200), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
    .digit_a(digit_a), .digit_b(digit_b), .digit_c(digit_c), .digit_d(digit_d),
    .dp_out(dp_out), .hex_a(hex_a), .hex_b(hex_b), .hex_c(hex_c), .hex_d(hex_d),
    .hex_ok(hex_ok), .frame_valid(frame_valid), .stale(stale)
  );

  function automatic frame_t cur_frame();
    return {digit_d, digit_c, digit_b, digit_a, dp_out, hex_d, hex_c, hex_b, hex_a, hex_ok};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%h required=none", cur_frame());
      end else begin
        check("frame", 64'(cur_frame()), 64'(exp_q.pop_front()));
        check("frame_stale", 64'(stale), 64'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int i, input logic [7:0] p, input logic [3:0] d, input int n);
    an = ~(4'b0001 << i);
    seg = ~p;
    dp = ~d;
    cyc(n);
  endtask

  task automatic scan(input frame_t f, input bit push);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && push) exp_q.push_back(f);
      dig(i, f.dig[8*i +: 8], f.dpo, 20);
    end
  endtask

  frame_t f1, f2, f3, f4, f5;

  initial begin
    f1 = '{dig: 32'h4F5B063F, dpo: 4'b0010, hex: 16'h3210, ok: 4'hF};
    f2 = '{dig: 32'h4F5B0666, dpo: 4'b0010, hex: 16'h3214, ok: 4'hF};
    f3 = '{dig: 32'h6F7F077D, dpo: 4'b0101, hex: 16'h9876, ok: 4'hF};
    f4 = '{dig: 32'h5E397C77, dpo: 4'b1000, hex: 16'hDCBA, ok: 4'hF};
    f5 = '{dig: 32'h71CF4979, dpo: 4'b1001, hex: 16'hF30E, ok: 4'b1101};
    cyc(5);
    check("reset_outputs", 64'({cur_frame(), frame_valid, stale}), 64'b01);
    rst_n = 1'b1;
    cyc(3);
    check("stale_before_frame", 64'(stale), 64'd1);
    scan(f1, 1'b1);
    an = 4'hF;
    cyc(5);
    check("held_after_frame", 64'(cur_frame()), 64'(f1));
    an = 4'hE;
    dp = ~4'b0010;
    for (int k = 0; k < 6; k++) begin
      seg = (k % 2 != 0) ? ~8'h11 : ~8'h22;
      cyc(2);
    end
    check("no_capture_on_toggle", 64'(digit_a), 64'h3F);
    seg = ~8'h66;
    cyc(20);
    for (int i = 1; i < 4; i++) begin
      if (i == 3) exp_q.push_back(f2);
      dig(i, f2.dig[8*i +: 8], f2.dpo, 20);
    end
    check("digit_a_after_hold", 64'(digit_a), 64'h66);
    dig(0, f3.dig[7:0], f3.dpo, 20);
    dig(1, f3.dig[15:8], f3.dpo, 20);
    an = 4'hC;
    cyc(60);
    an = 4'hF;
    cyc(60);
    check("held_during_blank", 64'(cur_frame()), 64'(f2));
    dig(2, f3.dig[23:16], f3.dpo, 20);
    exp_q.push_back(f3);
    dig(3, f3.dig[31:24], f3.dpo, 20);
    an = 4'hF;
    cyc(150);
    check("stale_before_timeout", 64'(stale), 64'd0);
    cyc(100);
    check("stale_after_timeout", 64'(stale), 64'd1);
    check("retain_after_timeout", 64'(cur_frame()), 64'(f3));
    scan(f4, 1'b1);
    check("stale_cleared", 64'(stale), 64'd0);
    scan(f5, 1'b1);
    check("bad_pattern_hex_ok", 64'(hex_ok), 64'b1101);
    dig(0, 8'h3F, 4'h0, 20);
    dig(1, 8'h06, 4'h0, 20);
    an = 4'hF;
    rst_n = 1'b0;
    cyc(2);
    check("mid_frame_reset", 64'({cur_frame(), frame_valid, stale}), 64'b01);
    rst_n = 1'b1;
    dig(2, 8'h5B, 4'h0, 20);
    dig(3, 8'h4F, 4'h0, 20);
    check("partial_no_frame", 64'(stale), 64'd1);
    an = 4'hF;
    cyc(250);
    scan(f1, 1'b1);
    an = 4'hF;
    cyc(10);
    check("final_outputs", 64'(cur_frame()), 64'(f1));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
